// File: rtl/window_3x3_gen_pkg.sv
// window_3x3_gen_pkg: shared defaults and counter-width helper for the 3x3 window generator.
// Contents:
//   DEF_PIX_W / DEF_IMG_W / DEF_IMG_H  default pixel width and image geometry
//   cnt_w(n)                           bits needed to count 0..n-1
//   DEF_COL_W / DEF_ROW_W              column/row counter widths for the defaults
package window_3x3_gen_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_COL_W = cnt_w(DEF_IMG_W);
    localparam int DEF_ROW_W = cnt_w(DEF_IMG_H);

endpackage

// File: rtl/window_3x3_gen_if.sv
// window_3x3_gen_if: pixel-stream input and 3x3 window output bundle.
// Signals:
//   pix_in, pix_valid, sof        raster pixel stream into the generator
//   xm1ym1 .. xp1yp1              nine window pixels (x = column, y = row offset)
//   win_valid, frame_done         window strobe and end-of-frame pulse
// Modports:
//   master  the window generator (consumes the stream, drives the window)
//   slave   the stream source / window consumer
interface window_3x3_gen_if
    import window_3x3_gen_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             sof;
    logic [PIX_W-1:0] xm1ym1, xm1y0, xm1yp1;
    logic [PIX_W-1:0] x0ym1,  x0y0,  x0yp1;
    logic [PIX_W-1:0] xp1ym1, xp1y0, xp1yp1;
    logic             win_valid;
    logic             frame_done;

    modport master (
        input  pix_in, pix_valid, sof,
        output xm1ym1, xm1y0, xm1yp1, x0ym1, x0y0, x0yp1, xp1ym1, xp1y0, xp1yp1,
        output win_valid, frame_done
    );

    modport slave (
        output pix_in, pix_valid, sof,
        input  xm1ym1, xm1y0, xm1yp1, x0ym1, x0y0, x0yp1, xp1ym1, xp1y0, xp1yp1,
        input  win_valid, frame_done
    );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// line_buffer: one image row of storage, combinational read and synchronous write at one address.
// Ports:
//   clk    write clock
//   i_we   write enable
//   i_addr read/write address (column)
//   i_wdata data written at i_addr on the rising edge
//   o_rdata contents at i_addr before this cycle's write
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    // Contents are deliberately not reset; stale data is never presented as a valid window.
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: turns a raster pixel stream into 3x3 neighbourhoods for the median filter.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   window_3x3_gen_if.master: pix_in/pix_valid/sof in; nine window pixels,
//         win_valid and frame_done out
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input logic           clk,
    input logic           rst,
    window_3x3_gen_if.master bus
);
    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] r_col, w_col, w_col_nxt;
    logic [ROW_W-1:0] r_row, w_row, w_row_nxt;
    logic [PIX_W-1:0] w_lb0, w_lb1;
    // Window columns, index 0 = upper row (ym1), 2 = lower row (yp1).
    logic [2:0][PIX_W-1:0] r_cm1, r_c0, r_cp1, w_new;
    logic w_acc, w_last_col, w_last_row;
    logic r_win_valid, r_frame_done;

    // sof makes the current pixel (0,0), so the line buffers are addressed by the
    // effective column rather than the stored counter.
    always_comb begin
        w_acc      = bus.pix_valid;
        w_col      = bus.sof ? '0 : r_col;
        w_row      = bus.sof ? '0 : r_row;
        w_last_col = w_col == LAST_COL;
        w_last_row = w_row == LAST_ROW;
        w_col_nxt  = w_last_col ? '0 : w_col + COL_W'(1);
        w_row_nxt  = !w_last_col ? w_row : (w_last_row ? '0 : w_row + ROW_W'(1));
        w_new      = {bus.pix_in, w_lb0, w_lb1};
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_addr  (w_col),
        .i_wdata (bus.pix_in),
        .o_rdata (w_lb0)
    );

    // Row r-2 is fed from row r-1's old value at the same column.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_addr  (w_col),
        .i_wdata (w_lb0),
        .o_rdata (w_lb1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_cm1        <= '0;
            r_c0         <= '0;
            r_cp1        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_acc && w_row >= ROW_W'(2) && w_col >= COL_W'(2);
            r_frame_done <= w_acc && w_last_col && w_last_row;
            if (w_acc) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                r_cm1 <= r_c0;
                r_c0  <= r_cp1;
                r_cp1 <= w_new;
            end
        end
    end

    assign bus.xm1ym1     = r_cm1[0];
    assign bus.xm1y0      = r_cm1[1];
    assign bus.xm1yp1     = r_cm1[2];
    assign bus.x0ym1      = r_c0[0];
    assign bus.x0y0       = r_c0[1];
    assign bus.x0yp1      = r_c0[2];
    assign bus.xp1ym1     = r_cp1[0];
    assign bus.xp1y0      = r_cp1[1];
    assign bus.xp1yp1     = r_cp1[2];
    assign bus.win_valid  = r_win_valid;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: randomized and directed stream checks of window_3x3_gen against an image-array model.
module tb_window_3x3_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    window_3x3_gen_if #(.PIX_W(8)) bus ();

    window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;

    // Model: the current frame as an image, indexed [row][col].
    int img [H][W];
    int m_row = 0;
    int m_col = 0;
    logic [71:0] exp_win = '0;
    logic exp_valid = 1'b0;
    logic exp_fd = 1'b0;
    logic win_known = 1'b1;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] obs_win();
        return {bus.xm1ym1, bus.xm1y0, bus.xm1yp1,
                bus.x0ym1,  bus.x0y0,  bus.x0yp1,
                bus.xp1ym1, bus.xp1y0, bus.xp1yp1};
    endfunction

    function automatic logic [7:0] px(input int r, input int c);
        return 8'(img[r][c]);
    endfunction

    task automatic step(input logic v, input logic s, input logic [7:0] p);
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        @(posedge clk);
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        if (v) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = int'(p);
            if (m_row >= 2 && m_col >= 2) begin
                exp_win = {px(m_row-2, m_col-2), px(m_row-1, m_col-2), px(m_row, m_col-2),
                           px(m_row-2, m_col-1), px(m_row-1, m_col-1), px(m_row, m_col-1),
                           px(m_row-2, m_col),   px(m_row-1, m_col),   px(m_row, m_col)};
                exp_valid = 1'b1;
                win_known = 1'b1;
            end else begin
                win_known = 1'b0;
            end
            exp_fd = (m_row == H-1 && m_col == W-1);
            if (m_col == W-1) begin
                m_col = 0;
                m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        @(negedge clk);
        check("win_valid", 72'(bus.win_valid), 72'(exp_valid));
        check("frame_done", 72'(bus.frame_done), 72'(exp_fd));
        if (win_known) check(exp_valid ? "window" : "window_hold", obs_win(), exp_win);
        if (bus.win_valid) n_valid++;
    endtask

    // Asserted between clock edges; outputs must clear before any edge arrives.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_window", obs_win(), '0);
        check("rst_win_valid", 72'(bus.win_valid), '0);
        check("rst_frame_done", 72'(bus.frame_done), '0);
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        m_row     = 0;
        m_col     = 0;
        exp_win   = '0;
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        win_known = 1'b1;
    endtask

    task automatic frame(input int base, input int gap_at, input int gap_n, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            step(1'b1, i == 0, 8'(base + 10*(i/W) + i%W));
            if (i == gap_at) repeat (gap_n) step(1'b0, 1'b0, 8'h5a);
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        @(negedge clk);
        async_reset();

        n_valid = 0;
        frame(0, -1, 0, W*H);
        check("valid_count_continuous", 72'(n_valid), 72'((H-2)*(W-2)));
        repeat (2) step(1'b0, 1'b0, 8'h00);

        n_valid = 0;
        frame(0, 2*W+2, 3, W*H);
        check("valid_count_gap", 72'(n_valid), 72'((H-2)*(W-2)));

        n_valid = 0;
        frame(0, -1, 0, W*H);
        frame(100, -1, 0, W*H);
        check("valid_count_two_frames", 72'(n_valid), 72'(2*(H-2)*(W-2)));

        frame(0, -1, 0, 2*W+1);
        n_valid = 0;
        frame(0, -1, 0, W*H);
        check("valid_count_resync", 72'(n_valid), 72'((H-2)*(W-2)));

        frame(0, -1, 0, 2*W+4);
        async_reset();
        n_valid = 0;
        frame(0, -1, 0, W*H);
        check("valid_count_after_rst", 72'(n_valid), 72'((H-2)*(W-2)));

        for (int i = 0; i < 400; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            step(v, ($urandom_range(0, 49) == 0), 8'($urandom));
        end
        repeat (2) step(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Upstream stage of the 3x3 median filter.
- Accepts a raster-order 8-bit pixel stream, one pixel per cycle when valid.
- Holds the two previous image rows in line buffers and a 3x3 shift window.
- Presents all nine neighbourhood pixels plus a window-valid strobe, ready to wire port-for-port into the median filter.

Parameters:
- IMG_W, 640, pixels per row (≥3).
- IMG_H, 480, rows per frame (≥3).
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pix_in  in  PIX_W  incoming pixel.
- pix_valid  in  1  pix_in is accepted this cycle.
- sof  in  1  start of frame; qualified by pix_valid; marks pixel (row 0, col 0).
- xm1ym1, xm1y0, xm1yp1, x0ym1, x0y0, x0yp1, xp1ym1, xp1y0, xp1yp1  out  PIX_W each  window pixels.
  - x = column offset, y = row offset relative to the centre.
  - m1 = −1, p1 = +1; ym1 is the upper row.
- win_valid  out  1  window outputs form a complete interior 3x3 neighbourhood.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=0, async):
  - col/row counters = 0.
  - All nine window outputs = 0.
  - win_valid = 0, frame_done = 0.
  - Line-buffer contents are not reset; they are never exposed while win_valid=1.
- Counters:
  - col 0..IMG_W−1, row 0..IMG_H−1; advance only on pix_valid.
  - col wraps to 0 and row increments.
  - After (IMG_H−1, IMG_W−1), both wrap to 0 and frame_done pulses the next cycle.
- sof:
  - pix_valid && sof forces the current pixel to be treated as (0,0).
  - Counters become col=1, row=0 afterwards, regardless of prior state (resync mid-frame).
  - No frame_done pulse is produced for the abandoned frame.
- Line buffers: two arrays of IMG_W entries, lb0 = row r−1, lb1 = row r−2, addressed by col.
  - Combinational read, synchronous write.
  - On an accepted pixel: lb1[col] <= lb0[col] (old value), lb0[col] <= pix_in.
- Window:
  - On an accepted pixel, the new column {lb1[col], lb0[col], pix_in} enters the right edge: xp1ym1, xp1y0, xp1yp1.
  - The existing xp1* column moves to x0*, and x0* moves to xm1*.
  - The window centre (x0y0) is pixel (row−1, col−1) of the accepted pixel.
- win_valid:
  - Registered; asserted the cycle after accepting a pixel with row ≥ 2 and col ≥ 2. Latency 1 cycle.
  - Low on any cycle following pix_valid=0; window registers hold their values.
  - Yields exactly (IMG_H−2)(IMG_W−2) valid windows per frame. Border pixels produce no window.
- Row boundary: no flush needed; col 0/1 windows are suppressed, so stale columns from the previous row never appear with win_valid=1.
- Frame boundary: rows 0/1 of the new frame overwrite the line buffers before any valid window, so there is no cross-frame contamination.
- Mid-frame reset: returns to the reset state. The next frame must begin with sof or starts at (0,0) anyway.

Decomposition:
- Shared package (img_pkg):
  - PIX_W, IMG_W, IMG_H defaults.
  - Counter widths $clog2(IMG_W) and $clog2(IMG_H).
- One sub-module, line_buffer:
  - Parameterised depth/width.
  - Combinational read at addr, write at the same addr (read returns the old value).
  - Instantiated twice.
- Counters, window registers and the valid/frame_done logic stay in the top.

Test Plan:
- IMG_W=5, IMG_H=4, continuous pix_valid, pixel value = 10·row+col, sof on the first pixel:
  - Accepting (2,2)=22 → next cycle win_valid=1, xm1ym1=0, x0y0=11, xp1yp1=22, xp1ym1=2, xm1yp1=20.
  - Exactly 6 valid windows per frame.
- Same stream with pix_valid deasserted for 3 cycles mid-row 2:
  - win_valid=0 during the gap; window outputs unchanged.
  - Windows after the gap are identical in value and order to the continuous run.
- Two back-to-back frames, the second with values +100:
  - frame_done pulses once after (3,4).
  - Second-frame first window has x0y0=111 and no first-frame values.
- sof asserted at (2,1) of frame 1 with a fresh frame following:
  - Counters resync and no frame_done for the aborted frame.
  - First valid window appears after the new (2,2) with x0y0=11.
- rst pulled low asynchronously mid-row 2:
  - Outputs zero immediately, with no clock edge required.
  - After release and a new frame with sof, the behaviour matches the first scenario exactly.
- Row-wrap check:
  - Pixels (3,0) and (3,1) produce no win_valid.
  - (3,2) produces a window with xm1ym1=10 and xp1yp1=32.
